// File: rtl/syndrome_ctrl.sv
// Feeds 128-bit RS(255,239) codeword beats to the syndrome engine and holds its result.
// Beats reach the engine 1 cycle after accept; s_ready is low from codeword end until m_ready takes the result.
module syndrome_ctrl #(
    parameter int BEATS    = 16,
    parameter int WAIT_MAX = 31
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] s_data,
    input  logic         s_valid,
    input  logic         s_last,
    output logic         s_ready,
    output logic [127:0] eng_data,
    output logic         eng_valid,
    output logic         eng_first,
    input  logic [127:0] eng_syndrome,
    input  logic         eng_done,
    output logic [127:0] m_syndrome,
    output logic         m_nonzero,
    output logic         m_len_err,
    output logic         m_timeout,
    output logic         m_valid,
    input  logic         m_ready
);

    localparam int CW = $clog2(BEATS) + 1;
    localparam int WW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] BEATS_C   = CW'(BEATS);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_WAIT,
        ST_HOLD
    } state_t;

    typedef struct packed {
        logic [127:0] syndrome;
        logic         len_err;
        logic         timeout;
    } res_t;

    state_t        state, state_n;
    logic [CW-1:0] beat_cnt, beat_cnt_n, beat_num;
    logic [WW-1:0] wait_cnt, wait_cnt_n;
    res_t          res_q;
    logic          accept;
    logic          cw_end;
    logic          len_err_n;
    logic          res_ok;
    logic          res_to;
    logic          out_taken;

    assign s_ready = (state == ST_IDLE) || (state == ST_FEED);
    assign accept  = s_valid && s_ready;

    // Beat number of the beat being accepted this cycle; IDLE always starts a new codeword.
    assign beat_num = (state == ST_IDLE) ? CW'(1) : beat_cnt + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            beat_cnt <= beat_cnt_n;
            wait_cnt <= wait_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        beat_cnt_n = beat_cnt;
        wait_cnt_n = wait_cnt;
        cw_end     = 1'b0;
        len_err_n  = res_q.len_err;
        res_ok     = 1'b0;
        res_to     = 1'b0;
        out_taken  = 1'b0;
        case (state)
            ST_IDLE, ST_FEED: begin
                if (accept) begin
                    beat_cnt_n = beat_num;
                    if (s_last || (beat_num == BEATS_C)) begin
                        state_n    = ST_WAIT;
                        wait_cnt_n = '0;
                        cw_end     = 1'b1;
                        len_err_n  = !(s_last && (beat_num == BEATS_C));
                    end else begin
                        state_n = ST_FEED;
                    end
                end
            end
            ST_WAIT: begin
                if (eng_done) begin
                    res_ok  = 1'b1;
                    state_n = ST_HOLD;
                end else if (wait_cnt == WAIT_LAST) begin
                    res_to  = 1'b1;
                    state_n = ST_HOLD;
                end else begin
                    wait_cnt_n = wait_cnt + WW'(1);
                end
            end
            ST_HOLD: begin
                if (m_ready) begin
                    out_taken  = 1'b1;
                    beat_cnt_n = '0;
                    state_n    = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_data  <= '0;
            eng_valid <= 1'b0;
            eng_first <= 1'b0;
        end else begin
            eng_valid <= accept;
            eng_first <= accept && (state == ST_IDLE);
            if (accept) begin
                eng_data <= s_data;
            end
        end
    end

    // Result fields only change on codeword end or engine/timeout completion, so HOLD is stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            m_valid <= 1'b0;
        end else begin
            if (cw_end) begin
                res_q.len_err <= len_err_n;
            end
            if (res_ok) begin
                res_q.syndrome <= eng_syndrome;
                res_q.timeout  <= 1'b0;
                m_valid        <= 1'b1;
            end else if (res_to) begin
                res_q.syndrome <= '0;
                res_q.timeout  <= 1'b1;
                m_valid        <= 1'b1;
            end else if (out_taken) begin
                m_valid <= 1'b0;
            end
        end
    end

    assign m_syndrome = res_q.syndrome;
    assign m_len_err  = res_q.len_err;
    assign m_timeout  = res_q.timeout;
    assign m_nonzero  = |res_q.syndrome;

endmodule

// File: tb/tb_syndrome_ctrl.sv
// Directed bench for syndrome_ctrl (BEATS=16, WAIT_MAX=31); inputs driven and outputs sampled on negedge.
module tb_syndrome_ctrl;

    logic         clk;
    logic         rst_n;
    logic [127:0] s_data;
    logic         s_valid;
    logic         s_last;
    logic         s_ready;
    logic [127:0] eng_data;
    logic         eng_valid;
    logic         eng_first;
    logic [127:0] eng_syndrome;
    logic         eng_done;
    logic [127:0] m_syndrome;
    logic         m_nonzero;
    logic         m_len_err;
    logic         m_timeout;
    logic         m_valid;
    logic         m_ready;

    int errors = 0;
    int checks = 0;

    syndrome_ctrl #(.BEATS(16), .WAIT_MAX(31)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .eng_data     (eng_data),
        .eng_valid    (eng_valid),
        .eng_first    (eng_first),
        .eng_syndrome (eng_syndrome),
        .eng_done     (eng_done),
        .m_syndrome   (m_syndrome),
        .m_nonzero    (m_nonzero),
        .m_len_err    (m_len_err),
        .m_timeout    (m_timeout),
        .m_valid      (m_valid),
        .m_ready      (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pat(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {8{b, 8'hA5}};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Drives beats first..last_beat back to back (s_valid left high), checking each engine beat.
    task automatic send_beats(input int first, input int last_beat, input int last_at);
        for (int i = first; i <= last_beat; i++) begin
            check1($sformatf("s_ready_b%0d", i), s_ready, 1'b1);
            s_valid = 1'b1;
            s_data  = pat(i);
            s_last  = (i == last_at);
            tick();
            check1($sformatf("eng_valid_b%0d", i), eng_valid, 1'b1);
            check1($sformatf("eng_first_b%0d", i), eng_first, (i == 1));
            check($sformatf("eng_data_b%0d", i), eng_data, pat(i));
        end
    endtask

    task automatic engine(input logic [127:0] syn);
        eng_syndrome = syn;
        eng_done     = 1'b1;
        tick();
        eng_done     = 1'b0;
    endtask

    task automatic take_result();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check1("taken_m_valid", m_valid, 1'b0);
        check1("taken_s_ready", s_ready, 1'b1);
    endtask

    logic [127:0] syn;
    logic         seen;

    initial begin
        rst_n        = 1'b0;
        s_data       = '0;
        s_valid      = 1'b0;
        s_last       = 1'b0;
        eng_syndrome = '0;
        eng_done     = 1'b0;
        m_ready      = 1'b0;
        tick();
        tick();
        check1("rst_s_ready", s_ready, 1'b1);
        check1("rst_eng_valid", eng_valid, 1'b0);
        check1("rst_eng_first", eng_first, 1'b0);
        check("rst_eng_data", eng_data, '0);
        check1("rst_m_valid", m_valid, 1'b0);
        check("rst_m_syndrome", m_syndrome, '0);
        check1("rst_m_len_err", m_len_err, 1'b0);
        check1("rst_m_timeout", m_timeout, 1'b0);
        rst_n = 1'b1;
        tick();

        // Clean 16-beat codeword, zero syndrome
        send_beats(1, 16, 16);
        s_valid = 1'b0;
        check1("cw1_s_ready_wait", s_ready, 1'b0);
        tick();
        check1("cw1_eng_valid_idle", eng_valid, 1'b0);
        check1("cw1_m_valid_pre", m_valid, 1'b0);
        engine('0);
        check1("cw1_m_valid", m_valid, 1'b1);
        check1("cw1_m_nonzero", m_nonzero, 1'b0);
        check1("cw1_m_len_err", m_len_err, 1'b0);
        check1("cw1_m_timeout", m_timeout, 1'b0);
        take_result();

        // S_3 = 0x5A, result held under backpressure; a stray eng_done in HOLD is ignored
        send_beats(1, 16, 16);
        s_valid = 1'b0;
        syn = 128'h5A << 24;
        engine(syn);
        check("s3_byte", 128'(m_syndrome[31:24]), 128'h5A);
        check("s3_syndrome", m_syndrome, syn);
        check1("s3_m_nonzero", m_nonzero, 1'b1);
        s_valid = 1'b1;
        s_data  = pat(99);
        s_last  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            eng_done     = (c == 4);
            eng_syndrome = 128'hFFFF;
            tick();
            check($sformatf("hold_syn_c%0d", c), m_syndrome, syn);
            check($sformatf("hold_ctl_c%0d", c),
                  128'({m_valid, s_ready, eng_valid, m_timeout, m_len_err}), 128'(5'b10000));
        end
        eng_done = 1'b0;
        s_valid  = 1'b0;
        take_result();

        // Short codeword: s_last on beat 9
        send_beats(1, 9, 9);
        s_valid = 1'b0;
        check1("short_s_ready", s_ready, 1'b0);
        tick();
        check1("short_eng_valid", eng_valid, 1'b0);
        engine('0);
        check1("short_m_valid", m_valid, 1'b1);
        check1("short_m_len_err", m_len_err, 1'b1);
        take_result();

        // Beat 16 without s_last
        send_beats(1, 16, 0);
        s_valid = 1'b0;
        check1("nolast_s_ready", s_ready, 1'b0);
        engine(128'h1);
        check1("nolast_m_valid", m_valid, 1'b1);
        check1("nolast_m_len_err", m_len_err, 1'b1);
        check1("nolast_m_nonzero", m_nonzero, 1'b1);
        take_result();

        // Engine never answers: timeout exactly 31 cycles after entering WAIT
        send_beats(1, 16, 16);
        s_valid = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            seen = seen | m_valid;
        end
        check1("to_early_valid", seen, 1'b0);
        tick();
        check1("to_m_valid", m_valid, 1'b1);
        check1("to_m_timeout", m_timeout, 1'b1);
        check("to_m_syndrome", m_syndrome, '0);
        check1("to_m_nonzero", m_nonzero, 1'b0);
        check1("to_m_len_err", m_len_err, 1'b0);
        take_result();

        // Reset after beat 7 discards the partial codeword
        send_beats(1, 7, 0);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        check1("mid_rst_eng_valid", eng_valid, 1'b0);
        check("mid_rst_eng_data", eng_data, '0);
        check1("mid_rst_m_timeout", m_timeout, 1'b0);
        check1("mid_rst_m_valid", m_valid, 1'b0);
        check1("mid_rst_s_ready", s_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        send_beats(1, 16, 16);
        s_valid = 1'b0;
        engine(128'h77 << 120);
        check1("post_rst_m_valid", m_valid, 1'b1);
        check("post_rst_syndrome", m_syndrome, 128'h77 << 120);
        check1("post_rst_len_err", m_len_err, 1'b0);
        take_result();

        // Back-to-back codewords, m_ready and s_valid held high
        m_ready = 1'b1;
        send_beats(1, 16, 16);
        s_data = pat(1);
        s_last = 1'b0;
        engine('0);
        check1("b2b_hold_m_valid", m_valid, 1'b1);
        check1("b2b_hold_s_ready", s_ready, 1'b0);
        check1("b2b_hold_eng_valid", eng_valid, 1'b0);
        tick();
        check1("b2b_idle_m_valid", m_valid, 1'b0);
        check1("b2b_idle_s_ready", s_ready, 1'b1);
        check1("b2b_idle_eng_valid", eng_valid, 1'b0);
        tick();
        check1("b2b_b1_eng_valid", eng_valid, 1'b1);
        check1("b2b_b1_eng_first", eng_first, 1'b1);
        check("b2b_b1_eng_data", eng_data, pat(1));
        send_beats(2, 16, 16);
        s_valid = 1'b0;
        engine(128'h3);
        check1("b2b_cw2_m_valid", m_valid, 1'b1);
        check("b2b_cw2_syndrome", m_syndrome, 128'h3);
        tick();
        check1("b2b_cw2_taken", m_valid, 1'b0);
        m_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
